ofifo: RTL and testbench
========================

OFIFO -- requirements
Module: ofifo

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning the number of MAC-array columns (independent lanes).
REQ-002 The block SHALL have parameter bw, default 16, meaning the width of one partial-sum word per column.
REQ-003 The block SHALL have parameter depth, default 16, meaning entries per column lane (power of two, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port in, input, col*bw bits: column i data on bits [bw*(i+1)-1 : bw*i].
REQ-007 The block SHALL have port wr, input, col bits: wr[i] is the per-column push strobe for lane i.
REQ-008 The block SHALL have port rd, input, 1 bit: pop one full row (all lanes together).
REQ-009 The block SHALL have port out, output, col*bw bits: head word of every lane, with the same bit packing as in.
REQ-010 The block SHALL have port o_full, output, 1 bit: high when any lane holds depth entries.
REQ-011 The block SHALL have port o_ready, output, 1 bit: the exact inverse of o_full.
REQ-012 The block SHALL have port o_valid, output, 1 bit: high when every lane holds at least 1 entry.

Function
REQ-013 Each lane SHALL be an independent circular buffer with write pointer, read pointer and an occupancy count of width clog2(depth)+1, range 0..depth.
REQ-014 When wr[i]=1 and lane i count<depth, the lane SHALL store in lane-slice i at the write pointer, advance the write pointer, and raise its count by 1 at the next edge.
REQ-015 When wr[i]=1 and lane i count==depth, the write SHALL be dropped with no state change, even if rd pops in the same cycle.
REQ-016 Lanes SHALL be written independently; any subset of wr bits may be high in one cycle.
REQ-017 out SHALL be first-word-fall-through: combinationally, the entry at each lane's read pointer, with zero added latency.
REQ-018 A word written at edge N SHALL be visible on out and count toward o_valid from edge N onward, i.e. one cycle after wr is sampled.
REQ-019 When rd=1 and o_valid=1, every lane SHALL advance its read pointer and decrement its count by 1 at the next edge.
REQ-020 When rd=1 and o_valid=0, the read SHALL be ignored with no pointer or count change in any lane.
REQ-021 A simultaneous valid pop and accepted push on the same lane SHALL leave that lane's count unchanged while both pointers advance.
REQ-022 Pointers SHALL wrap from depth-1 to 0 with no gap and no data loss.
REQ-023 o_full, o_ready and o_valid SHALL be combinational decodes of the registered lane counts.
REQ-024 No output SHALL combinationally depend on in, wr or rd.

Reset
REQ-025 While reset=1, asynchronously and regardless of clk, the block SHALL clear all pointers and counts to 0 and all storage entries to 0.
REQ-026 While reset=1, the block SHALL drive out=0, o_full=0, o_ready=1 and o_valid=0.
REQ-027 A reset asserted mid-operation SHALL discard all buffered data.
REQ-028 The first accepted write SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-029 Reset then single row: after reset, pulse wr=8'hFF with lane i = 16'h0100+i for 1 cycle -> next cycle o_valid=1, out lane i = 16'h0100+i; rd=1 for 1 cycle -> o_valid=0.
REQ-030 Skewed columns: write lane 0 at cycle 0, lane 1 at cycle 1, ... lane 7 at cycle 7 -> o_valid=0 until the edge after lane 7's write, then 1, and out holds all 8 words.
REQ-031 Fill and overflow: push 17 rows with wr=8'hFF (values 0..16) -> o_full=1 and o_ready=0 after 16 rows, row 16 dropped; 16 pops return values 0..15 in order, then o_valid=0.
REQ-032 Wrap-around with streaming: after 12 pushes and 12 pops, stream 20 rows with simultaneous wr=8'hFF and rd=1 while o_valid=1 -> count stays constant, output order is preserved across the pointer wrap, and o_full never asserts.
REQ-033 Illegal read: rd=1 with lanes 0-6 holding 1 entry and lane 7 empty -> no count changes in any lane; after lane 7 is written, a single rd pops all 8 lanes together.
REQ-034 Reset mid-operation: reset asserted between clock edges with 5 rows buffered -> out=0, o_valid=0 and o_ready=1 immediately, with no clock edge required.

Source files
------------

// File: rtl/ofifo.sv
// Output FIFO for a MAC array: one independent circular buffer per column,
// written per-lane as partial sums drain out, popped a full row at a time.
// Head words fall through combinationally.

module ofifo_lane #(
  parameter int bw    = 16,
  parameter int depth = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [bw-1:0] i_din,
  input  logic          i_wr,
  input  logic          i_pop,
  output logic [bw-1:0] o_dout,
  output logic          o_nempty,
  output logic          o_full
);
  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [bw-1:0] r_mem [depth];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;

  // A push to a full lane is dropped even if a row pop happens this cycle.
  assign w_push   = i_wr && (r_cnt != FULL_CNT);
  assign o_dout   = r_mem[r_rptr];
  assign o_nempty = (r_cnt != '0);
  assign o_full   = (r_cnt == FULL_CNT);

  // Storage write; cleared on reset so the fall-through head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) r_mem[k] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  // Pointer and occupancy update; power-of-two depth makes wrap implicit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, i_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end
endmodule

module ofifo #(
  parameter int col   = 8,
  parameter int bw    = 16,
  parameter int depth = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [col*bw-1:0] in,
  input  logic [col-1:0]    wr,
  input  logic              rd,
  output logic [col*bw-1:0] out,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_valid
);
  logic [col-1:0][bw-1:0] w_din, w_dout;
  logic [col-1:0]         w_nempty, w_full;
  logic                   w_pop;

  assign w_din   = in;
  assign out     = w_dout;
  assign o_valid = &w_nempty;
  assign o_full  = |w_full;
  assign o_ready = ~o_full;
  // Row pop only when every lane has a word; otherwise ignored everywhere.
  assign w_pop   = rd & o_valid;

  for (genvar g = 0; g < col; g++) begin : g_lane
    ofifo_lane #(.bw(bw), .depth(depth)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .i_din   (w_din[g]),
      .i_wr    (wr[g]),
      .i_pop   (w_pop),
      .o_dout  (w_dout[g]),
      .o_nempty(w_nempty[g]),
      .o_full  (w_full[g])
    );
  end
endmodule

// File: tb/tb_ofifo.sv
// Directed bench for ofifo: reset, skew, fill/overflow, wrap streaming,
// illegal read and asynchronous mid-operation reset.
module tb_ofifo;
  localparam int COL = 8;
  localparam int BW  = 16;
  localparam int DW  = COL * BW;

  logic          clk = 0;
  logic          reset;
  logic [DW-1:0] din;
  logic [COL-1:0] wr;
  logic          rd;
  logic [DW-1:0] dout;
  logic          o_full, o_ready, o_valid;

  int n_checks = 0;
  int n_fail   = 0;

  ofifo #(.col(COL), .bw(BW), .depth(16)) dut (
    .clk(clk), .reset(reset), .in(din), .wr(wr), .rd(rd),
    .out(dout), .o_full(o_full), .o_ready(o_ready), .o_valid(o_valid)
  );

  always #5 clk = ~clk;

  // every lane gets base+lane
  function automatic logic [DW-1:0] lanes(input logic [BW-1:0] base);
    logic [DW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = base + BW'(i);
    return v;
  endfunction

  // same value in every lane
  function automatic logic [DW-1:0] rep(input logic [BW-1:0] x);
    logic [DW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = x;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] v;
    din = '0; wr = '0; rd = 0; reset = 1;
    #2;
    chk("rst_out", dout, '0);
    chk("rst_full", DW'(o_full), DW'(0));
    chk("rst_ready", DW'(o_ready), DW'(1));
    chk("rst_valid", DW'(o_valid), DW'(0));
    step();
    reset = 0;

    // single row
    din = lanes(16'h0100); wr = 8'hFF;
    step();
    wr = '0;
    chk("row_valid", DW'(o_valid), DW'(1));
    chk("row_out", dout, lanes(16'h0100));
    rd = 1;
    step();
    rd = 0;
    chk("row_pop_valid", DW'(o_valid), DW'(0));

    // skewed columns
    for (int k = 0; k < COL; k++) begin
      din = lanes(16'h0200); wr = COL'(1) << k;
      step();
      chk($sformatf("skew_valid_%0d", k), DW'(o_valid), DW'(k == COL-1));
    end
    wr = '0;
    chk("skew_out", dout, lanes(16'h0200));
    rd = 1; step(); rd = 0;
    chk("skew_pop_valid", DW'(o_valid), DW'(0));

    // fill and overflow
    for (int r = 0; r < 17; r++) begin
      din = rep(BW'(r)); wr = 8'hFF;
      step();
      chk($sformatf("fill_full_%0d", r), DW'(o_full), DW'(r >= 15));
      chk($sformatf("fill_ready_%0d", r), DW'(o_ready), DW'(r < 15));
    end
    wr = '0;
    for (int r = 0; r < 16; r++) begin
      chk($sformatf("drain_out_%0d", r), dout, rep(BW'(r)));
      rd = 1; step(); rd = 0;
    end
    chk("drain_valid", DW'(o_valid), DW'(0));
    chk("drain_full", DW'(o_full), DW'(0));

    // 12 pushes and 12 pops to move pointers
    for (int r = 0; r < 12; r++) begin
      din = rep(16'h0300 + BW'(r)); wr = 8'hFF; step();
    end
    wr = '0;
    for (int r = 0; r < 12; r++) begin
      chk($sformatf("p12_out_%0d", r), dout, rep(16'h0300 + BW'(r)));
      rd = 1; step(); rd = 0;
    end
    // prime 3 rows then stream across the wrap
    for (int r = 0; r < 3; r++) begin
      din = rep(16'h0400 + BW'(r)); wr = 8'hFF; step();
    end
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("stream_out_%0d", k), dout, rep(16'h0400 + BW'(k)));
      din = rep(16'h0403 + BW'(k)); wr = 8'hFF; rd = 1;
      step();
      chk($sformatf("stream_full_%0d", k), DW'(o_full), DW'(0));
      chk($sformatf("stream_valid_%0d", k), DW'(o_valid), DW'(1));
    end
    wr = '0; rd = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stream_tail_%0d", k), dout, rep(16'h0414 + BW'(k)));
      rd = 1; step(); rd = 0;
    end
    chk("stream_empty", DW'(o_valid), DW'(0));

    // illegal read with lane 7 empty
    din = lanes(16'h0500); wr = 8'h7F; step(); wr = '0;
    chk("ill_valid0", DW'(o_valid), DW'(0));
    rd = 1; step(); rd = 0;
    chk("ill_valid1", DW'(o_valid), DW'(0));
    wr = 8'h80; step(); wr = '0;
    chk("ill_valid2", DW'(o_valid), DW'(1));
    chk("ill_out", dout, lanes(16'h0500));
    rd = 1; step(); rd = 0;
    chk("ill_pop_valid", DW'(o_valid), DW'(0));

    // asynchronous reset with 5 rows buffered
    for (int r = 0; r < 5; r++) begin
      din = rep(16'h0600 + BW'(r)); wr = 8'hFF; step();
    end
    wr = '0;
    chk("pre_rst_out", dout, rep(16'h0600));
    #2 reset = 1;
    #1;
    chk("arst_out", dout, '0);
    chk("arst_valid", DW'(o_valid), DW'(0));
    chk("arst_ready", DW'(o_ready), DW'(1));
    chk("arst_full", DW'(o_full), DW'(0));
    step();
    reset = 0;
    v = lanes(16'h0700);
    din = v; wr = 8'hFF; step(); wr = '0;
    chk("post_rst_valid", DW'(o_valid), DW'(1));
    chk("post_rst_out", dout, v);
    rd = 1; step(); rd = 0;
    chk("post_rst_empty", DW'(o_valid), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
